// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with HI/LO registers: single-cycle multiply, 32-cycle restoring divide.
// Busy stalls the pipeline until DONE; a flush aborts the operation without touching HI/LO.
module mdu_iter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  mdu_op_i,
  input  logic [31:0] mdu_a_i,
  input  logic [31:0] mdu_b_i,
  input  logic        mdu_flush_i,
  output logic        mdu_busy_o,
  output logic        mdu_done_o,
  output logic [31:0] mdu_result_o
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  localparam logic [3:0] OP_DIV   = 4'd1;
  localparam logic [3:0] OP_MUL   = 4'd3;
  localparam logic [3:0] OP_MULT  = 4'd4;
  localparam logic [3:0] OP_MULTU = 4'd5;
  localparam logic [3:0] OP_MFHI  = 4'd6;
  localparam logic [3:0] OP_MFLO  = 4'd7;
  localparam logic [3:0] OP_MTHI  = 4'd8;
  localparam logic [3:0] OP_MTLO  = 4'd9;

  state_t      state;
  logic [31:0] hi, lo, res;
  logic [31:0] a_q, b_q;
  logic [31:0] quo, rem;
  logic [3:0]  op_q;
  logic [4:0]  cnt;

  logic        accept;
  logic        sdiv;
  logic        smul;
  logic [31:0] a_in_mag;
  logic [31:0] div_mag;
  logic [32:0] rem_sh;
  logic        take;
  logic [31:0] q_nxt, r_nxt, q_fix, r_fix;
  logic [63:0] a_ext, b_ext, prod;

  assign accept   = (state == S_IDLE) && !mdu_flush_i && (mdu_op_i >= OP_DIV) && (mdu_op_i <= OP_MULTU);
  assign a_in_mag = (mdu_op_i == OP_DIV && mdu_a_i[31]) ? 32'd0 - mdu_a_i : mdu_a_i;

  // Divide datapath works on magnitudes; signs are restored from the captured raw operands.
  assign sdiv    = (op_q == OP_DIV);
  assign div_mag = (sdiv && b_q[31]) ? 32'd0 - b_q : b_q;
  assign rem_sh  = {rem, quo[31]};
  assign take    = rem_sh[32] || (rem_sh[31:0] >= div_mag);
  assign q_nxt   = {quo[30:0], take};
  assign r_nxt   = take ? rem_sh[31:0] - div_mag : rem_sh[31:0];
  assign q_fix   = (sdiv && (a_q[31] ^ b_q[31])) ? 32'd0 - q_nxt : q_nxt;
  assign r_fix   = (sdiv && a_q[31]) ? 32'd0 - r_nxt : r_nxt;

  assign smul  = (op_q == OP_MUL) || (op_q == OP_MULT);
  assign a_ext = {{32{smul & a_q[31]}}, a_q};
  assign b_ext = {{32{smul & b_q[31]}}, b_q};
  assign prod  = a_ext * b_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      hi    <= '0;
      lo    <= '0;
      res   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      quo   <= '0;
      rem   <= '0;
      op_q  <= '0;
      cnt   <= '0;
    end else if (mdu_flush_i) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q  <= mdu_op_i;
            a_q   <= mdu_a_i;
            b_q   <= mdu_b_i;
            quo   <= a_in_mag;
            rem   <= '0;
            cnt   <= '0;
            state <= (mdu_op_i >= OP_MUL) ? S_MUL : S_DIV;
          end else if (mdu_op_i == OP_MTHI) begin
            hi <= mdu_a_i;
          end else if (mdu_op_i == OP_MTLO) begin
            lo <= mdu_a_i;
          end
        end
        S_MUL: begin
          if (op_q == OP_MUL) res <= prod[31:0];
          else {hi, lo} <= prod;
          state <= S_DONE;
        end
        S_DIV: begin
          quo <= q_nxt;
          rem <= r_nxt;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state <= S_DONE;
            if (b_q == 32'd0) begin
              lo <= 32'hFFFF_FFFF;
              hi <= a_q;
            end else begin
              lo <= q_fix;
              hi <= r_fix;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    mdu_busy_o   = 1'b0;
    mdu_done_o   = 1'b0;
    mdu_result_o = '0;
    if (rst_n) begin
      case (state)
        S_IDLE: begin
          mdu_busy_o = accept;
          if (mdu_op_i == OP_MFHI)      mdu_result_o = hi;
          else if (mdu_op_i == OP_MFLO) mdu_result_o = lo;
        end
        S_MUL, S_DIV: mdu_busy_o = 1'b1;
        default: begin
          mdu_done_o   = 1'b1;
          mdu_result_o = (op_q == OP_MUL) ? res : lo;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Bench for mdu_iter: directed operations push expected results into a queue; a monitor
// pops and compares whenever the DUT presents a result (DONE or an IDLE MFHI/MFLO read).
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  mdu_op;
  logic [31:0] mdu_a, mdu_b;
  logic        mdu_flush;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  string       nm_q[$];
  logic [31:0] mon_e;
  string       mon_n;

  mdu_iter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mdu_op_i     (mdu_op),
    .mdu_a_i      (mdu_a),
    .mdu_b_i      (mdu_b),
    .mdu_flush_i  (mdu_flush),
    .mdu_busy_o   (busy),
    .mdu_done_o   (done),
    .mdu_result_o (result)
  );

  always #5 clk = ~clk;

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && (done === 1'b1 ||
        (busy === 1'b0 && mdu_flush === 1'b0 && (mdu_op == 4'd6 || mdu_op == 4'd7)))) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h expected none", result);
      end else begin
        mon_e = exp_q.pop_front();
        mon_n = nm_q.pop_front();
        chk32(mon_n, result, mon_e);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1.
  task automatic mt(input logic [3:0] op, input logic [31:0] a, input logic fl);
    mdu_op = op; mdu_a = a; mdu_flush = fl;
    @(negedge clk);
    chk32("mt_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    mdu_op = 4'd0; mdu_a = '0; mdu_flush = 1'b0;
  endtask

  task automatic mf(input logic [3:0] op, input logic [31:0] exp, input string nm);
    exp_q.push_back(exp); nm_q.push_back(nm);
    mdu_op = op;
    @(negedge clk);
    chk32({nm, "_busy"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    mdu_op = 4'd0;
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int exp_busy, input logic [31:0] exp_res, input string nm);
    int nb;
    bit seen;
    nb = 0; seen = 0;
    exp_q.push_back(exp_res); nm_q.push_back(nm);
    mdu_op = op; mdu_a = a; mdu_b = b;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        chk32({nm, "_busy_in_done"}, 32'(busy), 32'd0);
      end else if (busy) nb++;
      @(posedge clk); #1;
    end
    mdu_op = 4'd0; mdu_a = '0; mdu_b = '0;
    chk32({nm, "_done_seen"}, 32'(seen), 32'd1);
    chk32({nm, "_busy_cycles"}, 32'(nb), 32'(exp_busy));
  endtask

  initial begin
    int nb;
    int nd;
    rst_n = 1'b0; mdu_op = 4'd1; mdu_a = 32'd7; mdu_b = 32'd2; mdu_flush = 1'b0;
    #3;
    chk32("rst_busy", 32'(busy), 32'd0);
    chk32("rst_done", 32'(done), 32'd0);
    chk32("rst_result", result, 32'd0);
    mdu_op = 4'd6; #1;
    chk32("rst_hi", result, 32'd0);
    mdu_op = 4'd0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    mt(4'd8, 32'h1234_5678, 1'b0);
    mt(4'd9, 32'h9ABC_DEF0, 1'b0);
    mf(4'd6, 32'h1234_5678, "mfhi_basic");
    mf(4'd7, 32'h9ABC_DEF0, "mflo_basic");

    run_op(4'd4, 32'hFFFF_FFFF, 32'd2, 2, 32'hFFFF_FFFE, "mult");
    mf(4'd6, 32'hFFFF_FFFF, "mult_hi");
    mf(4'd7, 32'hFFFF_FFFE, "mult_lo");
    run_op(4'd5, 32'hFFFF_FFFF, 32'd2, 2, 32'hFFFF_FFFE, "multu");
    mf(4'd6, 32'h0000_0001, "multu_hi");
    mf(4'd7, 32'hFFFF_FFFE, "multu_lo");
    mt(4'd8, 32'h55, 1'b0);
    mt(4'd9, 32'h66, 1'b0);
    run_op(4'd3, 32'hFFFF_FFFF, 32'd2, 2, 32'hFFFF_FFFE, "mul");
    mf(4'd6, 32'h55, "mul_hi_kept");
    mf(4'd7, 32'h66, "mul_lo_kept");

    run_op(4'd1, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, "div_neg");
    mf(4'd6, 32'hFFFF_FFFF, "div_neg_hi");
    run_op(4'd2, 32'd7, 32'd2, 33, 32'd3, "divu");
    mf(4'd6, 32'd1, "divu_hi");
    run_op(4'd1, 32'd7, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFD, "div_negb");
    mf(4'd6, 32'd1, "div_negb_hi");
    run_op(4'd1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, "div_ovf");
    mf(4'd6, 32'd0, "div_ovf_hi");
    run_op(4'd2, 32'd5, 32'd0, 33, 32'hFFFF_FFFF, "divu_zero");
    mf(4'd6, 32'd5, "divu_zero_hi");
    run_op(4'd1, 32'hFFFF_FFF9, 32'd0, 33, 32'hFFFF_FFFF, "div_zero");
    mf(4'd6, 32'hFFFF_FFF9, "div_zero_hi");

    // Flush on the 10th busy cycle of a divide.
    mt(4'd8, 32'hA, 1'b0);
    mt(4'd9, 32'hB, 1'b0);
    mdu_op = 4'd1; mdu_a = 32'd100; mdu_b = 32'd3;
    nb = 0;
    for (int i = 0; i < 50 && nb < 10; i++) begin
      @(negedge clk);
      if (busy) nb++;
    end
    chk32("flush_reach_cycle10", 32'(nb), 32'd10);
    mdu_flush = 1'b1;
    @(posedge clk); #1;
    mdu_flush = 1'b0; mdu_op = 4'd0; mdu_a = '0; mdu_b = '0;
    @(negedge clk);
    chk32("flush_busy_next", 32'(busy), 32'd0);
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk32("flush_no_done", 32'(nd), 32'd0);
    @(posedge clk); #1;
    mf(4'd6, 32'hA, "flush_hi");
    mf(4'd7, 32'hB, "flush_lo");
    mt(4'd8, 32'hDEAD, 1'b1);
    mf(4'd6, 32'hA, "flush_mthi_hi");

    // Reset during the 20th busy cycle of a divide.
    mdu_op = 4'd1; mdu_a = 32'd100; mdu_b = 32'd3;
    nb = 0;
    for (int i = 0; i < 50 && nb < 20; i++) begin
      @(negedge clk);
      if (busy) nb++;
    end
    chk32("rst_reach_cycle20", 32'(nb), 32'd20);
    #1 rst_n = 1'b0;
    #1;
    chk32("midrst_busy", 32'(busy), 32'd0);
    chk32("midrst_done", 32'(done), 32'd0);
    mdu_op = 4'd6; #1;
    chk32("midrst_hi", result, 32'd0);
    mdu_op = 4'd7; #1;
    chk32("midrst_lo", result, 32'd0);
    mdu_op = 4'd0; mdu_a = '0; mdu_b = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(4'd5, 32'd3, 32'd4, 2, 32'd12, "multu_after_rst");
    mf(4'd6, 32'd0, "after_rst_hi");
    mf(4'd7, 32'd12, "after_rst_lo");

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    chk32("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 32-bit operands and a 64-bit HI/LO pair.
REQ-002 The ports SHALL be, clock and reset first:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- mdu_op_i  in  4  operation code: 0 none, 1 DIV, 2 DIVU, 3 MUL, 4 MULT, 5 MULTU, 6 MFHI, 7 MFLO, 8 MTHI, 9 MTLO; codes 10-15 are treated as none.
- mdu_a_i  in  32  rs operand.
- mdu_b_i  in  32  rt operand.
- mdu_flush_i  in  1  pipeline flush; aborts any operation.
- mdu_busy_o  out  1  stall request; the pipeline holds the op and operands stable while this is high.
- mdu_done_o  out  1  high for one cycle in DONE.
- mdu_result_o  out  32  value for the rd writeback.

Function
REQ-003 The state machine SHALL have four states: IDLE, MUL, DIV, DONE.
REQ-004 In IDLE, with flush low and op in 1-5, the block SHALL capture a and b and the op, then go to MUL (ops 3-5) or to DIV (ops 1-2) with the iteration counter set to 0.
REQ-005 In IDLE, op 8 (MTHI) SHALL write HI <= a, and op 9 (MTLO) SHALL write LO <= a, at the next edge; the state stays IDLE and busy stays 0.
REQ-006 In IDLE, mdu_result_o SHALL be combinational: HI for op 6, LO for op 7, 0 otherwise.
REQ-007 mdu_busy_o SHALL be combinational:
- 1 in IDLE when op is 1-5 and flush is 0;
- 1 in MUL and in DIV;
- 0 in all other cases.
REQ-008 MUL state SHALL last one cycle and then go to DONE. On that edge it SHALL form the 64-bit product: signed for ops 3 and 4, unsigned for op 5.
- MULT/MULTU: {HI,LO} <= product.
- MUL: the result register <= product[31:0]; HI and LO are unchanged.
REQ-009 DIV state SHALL perform restoring radix-2 division on operand magnitudes (DIV) or raw values (DIVU), one quotient bit per cycle, for 32 cycles (counter 0-31). After the final iteration it SHALL go to DONE.
REQ-010 For DIV, the quotient SHALL be negated when the operand signs differ, and the remainder SHALL take the sign of the dividend.
REQ-011 Divide by zero (b==0) for DIV and DIVU SHALL give LO=32'hFFFFFFFF and HI=a, with no sign fix-up.
REQ-012 DIV 32'h80000000 / 32'hFFFFFFFF SHALL give LO=32'h80000000 and HI=0, with no exception.
REQ-013 HI and LO SHALL be written, for DIV/DIVU/MULT/MULTU, on the edge that enters DONE.
REQ-014 In DONE:
- mdu_busy_o=0 and mdu_done_o=1;
- mdu_result_o = the result register for MUL, and the new LO for the other ops;
- the next state is always IDLE, and the still-present op SHALL NOT be re-accepted.
REQ-015 In MUL and DIV, mdu_result_o SHALL be 0 and mdu_done_o SHALL be 0.
REQ-016 mdu_flush_i=1 in any state SHALL force IDLE at the next edge.
- Any in-flight result is discarded, and HI/LO are not updated.
- In IDLE, a flush SHALL suppress MTHI/MTLO writes and suppress acceptance.
- busy SHALL be 0 from the next cycle.
REQ-017 Flush SHALL take priority over completion: a flush in the last DIV cycle or in the MUL cycle SHALL prevent the HI/LO write.
REQ-018 Total latency SHALL be:
- MULT/MUL: busy for 2 cycles, DONE on the 3rd cycle;
- DIV/DIVU: busy for 33 cycles, DONE on the 34th cycle.

Reset
REQ-019 While rst_n=0, immediately and independent of clk, the block SHALL hold:
- state=IDLE, HI=0, LO=0, counter=0, result register=0, captured operands=0;
- mdu_busy_o=0, mdu_done_o=0, mdu_result_o=0.
REQ-020 Reset asserted mid-operation SHALL abandon the operation; after release, the first op is accepted normally.

Verification
REQ-021 MTHI a=32'h12345678, then MTLO a=32'h9ABCDEF0, then MFHI, then MFLO -> result 32'h12345678 then 32'h9ABCDEF0; busy stays 0 throughout.
REQ-022 MULT a=32'hFFFFFFFF, b=2 -> busy for 2 cycles, then HI=32'hFFFFFFFF, LO=32'hFFFFFFFE. MULTU with the same operands -> HI=1, LO=32'hFFFFFFFE. MUL with the same operands -> result 32'hFFFFFFFE in DONE, HI/LO unchanged.
REQ-023 DIV a=32'hFFFFFFF9, b=2 -> busy for 33 cycles, then LO=32'hFFFFFFFD, HI=32'hFFFFFFFF. DIVU a=7, b=2 -> LO=3, HI=1.
REQ-024 DIV 32'h80000000 / 32'hFFFFFFFF -> LO=32'h80000000, HI=0. DIVU a=5, b=0 -> LO=32'hFFFFFFFF, HI=5.
REQ-025 With HI=32'hA and LO=32'hB, issue DIV and assert flush on busy cycle 10 -> busy=0 on the next cycle, done never asserts, HI=32'hA, LO=32'hB.
REQ-026 Assert rst_n low on DIV cycle 20 -> busy, HI and LO go to 0 immediately. After release, MULTU 3×4 -> LO=12, HI=0.
